axis_zmod_decimator: RTL and testbench

- Boxcar-average decimator that sits directly downstream of the ZMOD ADC capture stage.
- Consumes the always-valid 32-bit stream of two sign-extended 16-bit samples (A in [15:0], B in [31:16]).
- Sums R consecutive samples per channel, shifts right, saturates to 16 bits, and emits one packed word per block on a backpressured AXI-Stream master.
- Results that arrive while the output register is still occupied are dropped and counted.

---
 rtl/axis_zmod_pkg.sv | 13 +
 rtl/axis_zmod_sat_shift.sv | 41 ++++
 rtl/axis_zmod_decimator.sv | 125 ++++++++++++
 tb/tb_axis_zmod_decimator.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/axis_zmod_pkg.sv
// Shared constants and the packed two-channel sample type for the ZMOD decimator.
package axis_zmod_pkg;

  localparam int CH_WIDTH = 16;
  localparam int SAT_MAX  = 32767;
  localparam int SAT_MIN  = -32768;

  typedef struct packed {
    logic signed [CH_WIDTH-1:0] b;
    logic signed [CH_WIDTH-1:0] a;
  } sample_t;

endpackage

// File: rtl/axis_zmod_sat_shift.sv
// One channel of block-sum post-processing: arithmetic shift, optional rounding, 16-bit saturation.
// Define AXIS_ZMOD_DECIMATOR_ROUNDING_EN for round-half-up; otherwise truncation toward -inf.
module axis_zmod_sat_shift
  import axis_zmod_pkg::*;
#(
  parameter int ACC_WIDTH = 32
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  input  logic        [4:0]           shift,
  output logic signed [CH_WIDTH-1:0]  result
);

  // One guard bit so the rounding bias cannot wrap a near-full-scale sum.
  localparam int EXT_W = ACC_WIDTH + 1;
  localparam logic signed [EXT_W-1:0] MAX_EXT = EXT_W'(SAT_MAX);
  localparam logic signed [EXT_W-1:0] MIN_EXT = EXT_W'(SAT_MIN);

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] biased;
  logic signed [EXT_W-1:0] shifted;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ext    = {sum[ACC_WIDTH-1], sum};
    biased = ext;
`ifdef AXIS_ZMOD_DECIMATOR_ROUNDING_EN
    if (shift != 5'd0) begin
      biased = ext + $signed((EXT_W'(1) << shift) >> 1);
    end
`endif
    shifted = biased >>> shift;
    if (shifted > MAX_EXT) begin
      result = CH_WIDTH'(SAT_MAX);
    end else if (shifted < MIN_EXT) begin
      result = CH_WIDTH'(SAT_MIN);
    end else begin
      result = shifted[CH_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/axis_zmod_decimator.sv
// Boxcar-average decimator for the ZMOD ADC stream: sum R samples per channel, shift, saturate, emit on AXIS.
// Optional rounding is selected with AXIS_ZMOD_DECIMATOR_ROUNDING_EN (see axis_zmod_sat_shift).
module axis_zmod_decimator
  import axis_zmod_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16,
  parameter int ACC_WIDTH        = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_ratio,
  input  logic [4:0]                  cfg_shift,
  input  logic                        s_axis_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [31:0]                 sts_drops
);

  sample_t in_s;
  assign in_s = s_axis_tdata[2*CH_WIDTH-1:0];

  logic [CNTR_WIDTH-1:0]       cnt, ratio_q, ratio_now;
  logic [4:0]                  shift_q, shift_now;
  logic signed [ACC_WIDTH-1:0] acc_a, acc_b, sx_a, sx_b, sum_a, sum_b;
  logic                        first, last;

  // Block framing: the first sample of a block picks up fresh cfg and restarts the sum.
  always_comb begin
    first     = (cnt == '0);
    ratio_now = first ? ((cfg_ratio == '0) ? CNTR_WIDTH'(1) : cfg_ratio) : ratio_q;
    shift_now = first ? cfg_shift : shift_q;
    sx_a      = {{(ACC_WIDTH-CH_WIDTH){in_s.a[CH_WIDTH-1]}}, in_s.a};
    sx_b      = {{(ACC_WIDTH-CH_WIDTH){in_s.b[CH_WIDTH-1]}}, in_s.b};
    sum_a     = (first ? '0 : acc_a) + sx_a;
    sum_b     = (first ? '0 : acc_b) + sx_b;
    last      = (cnt == ratio_now - CNTR_WIDTH'(1));
  end

  logic                        sum_valid;
  logic signed [ACC_WIDTH-1:0] sum_a_q, sum_b_q;
  logic [4:0]                  sum_shift_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt         <= '0;
      ratio_q     <= '0;
      shift_q     <= '0;
      acc_a       <= '0;
      acc_b       <= '0;
      sum_valid   <= 1'b0;
      sum_a_q     <= '0;
      sum_b_q     <= '0;
      sum_shift_q <= '0;
    end else begin
      sum_valid <= s_axis_tvalid & last;
      if (s_axis_tvalid) begin
        ratio_q <= ratio_now;
        shift_q <= shift_now;
        if (last) begin
          cnt         <= '0;
          acc_a       <= '0;
          acc_b       <= '0;
          sum_a_q     <= sum_a;
          sum_b_q     <= sum_b;
          sum_shift_q <= shift_now;
        end else begin
          cnt   <= cnt + CNTR_WIDTH'(1);
          acc_a <= sum_a;
          acc_b <= sum_b;
        end
      end
    end
  end

  logic signed [CH_WIDTH-1:0] sat_a, sat_b;

  axis_zmod_sat_shift #(.ACC_WIDTH(ACC_WIDTH)) u_sat_a (
    .sum    (sum_a_q),
    .shift  (sum_shift_q),
    .result (sat_a)
  );

  axis_zmod_sat_shift #(.ACC_WIDTH(ACC_WIDTH)) u_sat_b (
    .sum    (sum_b_q),
    .shift  (sum_shift_q),
    .result (sat_b)
  );

  logic    s1_valid;
  sample_t s1_q, out_q;

  // NOTE: datapath registers are reset too, because m_axis_tdata must read 0 out of reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid      <= 1'b0;
      s1_q          <= '0;
      out_q         <= '0;
      m_axis_tvalid <= 1'b0;
      sts_drops     <= '0;
    end else begin
      s1_valid <= sum_valid;
      if (sum_valid) begin
        s1_q <= '{b: sat_b, a: sat_a};
      end
      if (s1_valid) begin
        // A word accepted this cycle frees the register for the incoming result.
        if (!m_axis_tvalid || m_axis_tready) begin
          out_q         <= s1_q;
          m_axis_tvalid <= 1'b1;
        end else if (sts_drops != '1) begin
          sts_drops <= sts_drops + 32'd1;
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata = AXIS_TDATA_WIDTH'(out_q);

endmodule

// File: tb/tb_axis_zmod_decimator.sv
// Scoreboard bench for axis_zmod_decimator: expected words queued at drive time, popped as the DUT emits them.
module tb_axis_zmod_decimator;

`ifdef AXIS_ZMOD_DECIMATOR_ROUNDING_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] cfg_ratio = 16'd4;
  logic [4:0]  cfg_shift = 5'd2;
  logic        s_axis_tvalid = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic [31:0] sts_drops;

  axis_zmod_decimator dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_ratio     (cfg_ratio),
    .cfg_shift     (cfg_shift),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .sts_drops     (sts_drops)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // A word is new when tvalid rises or the previous word was accepted on the last edge.
  logic prev_v = 1'b0, prev_acc = 1'b0;
  always @(negedge aclk) begin
    exp_t e;
    if (m_axis_tvalid && (!prev_v || prev_acc)) begin
      if (q.size() == 0) begin
        check("spurious_word", m_axis_tdata, 32'hDEAD_BEEF ^ m_axis_tdata);
      end else begin
        e = q.pop_front();
        check("word", m_axis_tdata, e.data);
        check("latency", cyc, e.due);
      end
    end
    prev_v   = m_axis_tvalid;
    prev_acc = m_axis_tvalid & m_axis_tready;
  end

  // Drives one sample for one cycle; a block-closing sample queues its word, due 2 edges after capture.
  task automatic put(input logic [15:0] a, input logic [15:0] b, input bit push, input logic [31:0] exp);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {b, a};
    if (push) q.push_back('{data: exp, due: cyc + 3});
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = $urandom;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 32'h0);
    check("rst_drops", sts_drops, 32'h0);
    #21 aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Constant 100/-100, R=4, >>2, with an idle gap inside the second block.
    cfg_ratio = 16'd4;
    cfg_shift = 5'd2;
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 4; i++) begin
        if (blk == 1 && i == 2) idle(2);
        put(16'd100, 16'hFF9C, i == 3, 32'hFF9C_0064);
      end
    end
    idle(6);

    // Saturation in both directions.
    cfg_ratio = 16'd8;
    cfg_shift = 5'd0;
    for (int i = 0; i < 8; i++) put(16'd8191, 16'hE000, i == 7, 32'h8000_7FFF);
    idle(6);

    // Rounding vs truncation: (1+2)>>1.
    cfg_ratio = 16'd2;
    cfg_shift = 5'd1;
    put(16'd1, 16'd0, 1'b0, 32'h0);
    put(16'd2, 16'd0, 1'b1, ROUND ? 32'h0000_0002 : 32'h0000_0001);
    idle(6);

    // Pass-through ramp, back-to-back, continuously ready.
    cfg_ratio = 16'd0;
    cfg_shift = 5'd0;
    for (int k = 0; k < 8; k++) put(16'(k), 16'(-k), 1'b1, {16'(-k), 16'(k)});
    // cfg changes mid-block only apply at the next block start.
    cfg_ratio = 16'd4;
    put(16'd1, 16'd0, 1'b0, 32'h0);
    put(16'd2, 16'd0, 1'b0, 32'h0);
    cfg_ratio = 16'd2;
    cfg_shift = 5'd1;
    put(16'd3, 16'd0, 1'b0, 32'h0);
    put(16'd4, 16'd0, 1'b1, 32'h0000_000A);
    put(16'd5, 16'd0, 1'b0, 32'h0);
    put(16'd6, 16'd0, 1'b1, ROUND ? 32'h0000_0006 : 32'h0000_0005);
    idle(6);
    check("drops_none", sts_drops, 32'd0);

    // Backpressure: first of 5 results held, the other 4 dropped.
    cfg_ratio = 16'd1;
    cfg_shift = 5'd0;
    m_axis_tready = 1'b0;
    for (int k = 0; k < 5; k++) put(16'(42 + k), 16'd0, k == 0, 32'h0000_002A);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("hold_tdata", m_axis_tdata, 32'h0000_002A);
      check("hold_tvalid", m_axis_tvalid, 1'b1);
    end
    check("drops_four", sts_drops, 32'd4);
    m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;
    check("tvalid_fall", m_axis_tvalid, 1'b0);
    check("drops_kept", sts_drops, 32'd4);

    // Async reset with a held word, a drop and a half-filled block pending.
    m_axis_tready = 1'b0;
    put(16'd5, 16'd5, 1'b1, 32'h0005_0005);
    put(16'd6, 16'd6, 1'b0, 32'h0);
    idle(3);
    check("pre_rst_drops", sts_drops, 32'd5);
    cfg_ratio = 16'd4;
    put(16'd7, 16'd7, 1'b0, 32'h0);
    put(16'd7, 16'd7, 1'b0, 32'h0);
    s_axis_tvalid = 1'b0;
    #3 aresetn = 1'b0;
    #1;
    check("arst_tvalid", m_axis_tvalid, 1'b0);
    check("arst_tdata", m_axis_tdata, 32'h0);
    check("arst_drops", sts_drops, 32'h0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    cfg_shift = 5'd0;
    for (int i = 0; i < 4; i++) put(16'd1, 16'hFFFF, i == 3, 32'hFFFC_0004);
    idle(8);
    check("queue_empty", 32'(q.size()), 32'd0);
    check("drops_final", sts_drops, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
